// File: rtl/rect_flip_sequencer.sv
// rect_flip_sequencer: walks a rectangle of words in BRAM through a byte-serial
// adapter and rewrites each word in place after a selectable flip transform.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 begin a walk (sampled only when idle)
//   rect_base/rect_w/rect_h/row_stride/flip_mode  walk config, latched on start
//   st_read/st_write      one-cycle request pulses to the adapter
//   base_addr/write_data  address and write word held for the adapter
//   read_data/flip_ready  read word and read-complete pulse from the adapter
//   wrt_done              write-complete pulse from the adapter
//   busy/done/error       walk status; error is the sticky handshake timeout
//
// Optional feature: define RECT_FLIP_TIMEOUT_EN to bound each adapter
// handshake to TIMEOUT cycles; otherwise waits are unbounded and error is 0.
module rect_flip_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_BYTES = 2,
    parameter int ADDR_W     = 8,
    parameter int DIM_W      = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic [ADDR_W-1:0]                rect_base,
    input  logic [DIM_W-1:0]                 rect_w,
    input  logic [DIM_W-1:0]                 rect_h,
    input  logic [ADDR_W-1:0]                row_stride,
    input  logic [1:0]                       flip_mode,
    output logic                             st_read,
    output logic                             st_write,
    output logic [ADDR_W-1:0]                base_addr,
    output logic [DATA_WIDTH*WORD_BYTES-1:0] write_data,
    input  logic [DATA_WIDTH*WORD_BYTES-1:0] read_data,
    input  logic                             flip_ready,
    input  logic                             wrt_done,
    output logic                             busy,
    output logic                             done,
    output logic                             error
);

    localparam int W = DATA_WIDTH * WORD_BYTES;
    localparam logic [ADDR_W-1:0] WSTEP = ADDR_W'(WORD_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        FLIP,
        WR_REQ,
        WR_WAIT,
        NEXT,
        DONE
    } state_t;

    state_t            state;
    logic [DIM_W-1:0]  w_r;
    logic [DIM_W-1:0]  h_r;
    logic [ADDR_W-1:0] stride_r;
    logic [1:0]        mode_r;
    logic [ADDR_W-1:0] row_addr;
    logic [DIM_W-1:0]  col;
    logic [DIM_W-1:0]  row;
    logic [W-1:0]      word_r;

    // Lane 0 is the lowest byte; byte-reverse mirrors lanes, bit-reverse
    // mirrors the whole word.
    function automatic logic [W-1:0] flip_word(
        input logic [W-1:0] d,
        input logic [1:0]   m
    );
        logic [W-1:0] r;
        r = d;
        unique case (m)
            2'b00: r = d;
            2'b01: begin
                for (int i = 0; i < WORD_BYTES; i++)
                    r[i*DATA_WIDTH +: DATA_WIDTH] =
                        d[(WORD_BYTES-1-i)*DATA_WIDTH +: DATA_WIDTH];
            end
            2'b10: begin
                for (int i = 0; i < W; i++)
                    r[i] = d[W-1-i];
            end
            default: r = ~d;
        endcase
        return r;
    endfunction

    logic              last_col;
    logic              last_row;
    logic [DIM_W-1:0]  col_inc;
    logic [ADDR_W-1:0] next_row_addr;
    logic [ADDR_W-1:0] next_col_addr;

    assign last_col      = (col == w_r - DIM_W'(1));
    assign last_row      = (row == h_r - DIM_W'(1));
    assign col_inc       = col + DIM_W'(1);
    assign next_row_addr = row_addr + stride_r;
    assign next_col_addr = row_addr + ADDR_W'(col_inc) * WSTEP;

`ifdef RECT_FLIP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
    logic          err_r;
    logic          tmo_hit;
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));
    assign error   = err_r;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            st_read    <= 1'b0;
            st_write   <= 1'b0;
            base_addr  <= '0;
            write_data <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            w_r        <= '0;
            h_r        <= '0;
            stride_r   <= '0;
            mode_r     <= '0;
            row_addr   <= '0;
            col        <= '0;
            row        <= '0;
            word_r     <= '0;
`ifdef RECT_FLIP_TIMEOUT_EN
            tmo_cnt    <= '0;
            err_r      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        w_r       <= rect_w;
                        h_r       <= rect_h;
                        stride_r  <= row_stride;
                        mode_r    <= flip_mode;
                        row_addr  <= rect_base;
                        col       <= '0;
                        row       <= '0;
                        busy      <= 1'b1;
`ifdef RECT_FLIP_TIMEOUT_EN
                        err_r     <= 1'b0;
`endif
                        // Empty rectangle finishes without touching BRAM.
                        if (rect_w == '0 || rect_h == '0) begin
                            state <= DONE;
                        end else begin
                            base_addr <= rect_base;
                            st_read   <= 1'b1;
                            state     <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    st_read <= 1'b0;
`ifdef RECT_FLIP_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    state   <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (flip_ready) begin
                        word_r <= read_data;
                        state  <= FLIP;
                    end
`ifdef RECT_FLIP_TIMEOUT_EN
                    else if (tmo_hit) begin
                        err_r <= 1'b1;
                        state <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
`endif
                end
                FLIP: begin
                    write_data <= flip_word(word_r, mode_r);
                    st_write   <= 1'b1;
                    state      <= WR_REQ;
                end
                WR_REQ: begin
                    st_write <= 1'b0;
`ifdef RECT_FLIP_TIMEOUT_EN
                    tmo_cnt  <= '0;
`endif
                    state    <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (wrt_done) begin
                        state <= NEXT;
                    end
`ifdef RECT_FLIP_TIMEOUT_EN
                    else if (tmo_hit) begin
                        err_r <= 1'b1;
                        state <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
`endif
                end
                NEXT: begin
                    if (last_col) begin
                        col      <= '0;
                        row      <= row + DIM_W'(1);
                        row_addr <= next_row_addr;
                        if (last_row) begin
                            state <= DONE;
                        end else begin
                            base_addr <= next_row_addr;
                            st_read   <= 1'b1;
                            state     <= RD_REQ;
                        end
                    end else begin
                        col       <= col_inc;
                        base_addr <= next_col_addr;
                        st_read   <= 1'b1;
                        state     <= RD_REQ;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
